// File: rtl/imem_loader_if.sv
// imem_loader_if
//   Groups the loader's byte-stream handshake and IMEM write bus.
//   master : byte source / observer side (drives start, in_valid, in_data)
//   slave  : the loader itself (drives in_ready, IMEM write port and status)
//   Signals:
//     start      - begin a new load
//     in_valid   - in_data holds a byte
//     in_data    - stream byte
//     in_ready   - loader accepts a byte this cycle
//     imem_we    - IMEM write strobe, one cycle per word
//     imem_addr  - IMEM word address (AWIDTH bits)
//     imem_wdata - instruction word
//     cpu_hold   - core held in reset while 1
//     done       - load completed with good checksum
//     error      - load aborted
//     word_cnt   - words written in the current or last load
interface imem_loader_if #(
    parameter int AWIDTH = 10
);
    logic              start;
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              imem_we;
    logic [AWIDTH-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              cpu_hold;
    logic              done;
    logic              error;
    logic [15:0]       word_cnt;

    modport master (
        output start, in_valid, in_data,
        input  in_ready, imem_we, imem_addr, imem_wdata,
               cpu_hold, done, error, word_cnt
    );

    modport slave (
        input  start, in_valid, in_data,
        output in_ready, imem_we, imem_addr, imem_wdata,
               cpu_hold, done, error, word_cnt
    );
endinterface

// File: rtl/imem_loader.sv
// imem_loader
//   Byte-stream program loader feeding the instruction memory write port.
//   Frame: LEN0, LEN1 (word count, little-endian), count*4 data bytes
//   (little-endian words), one XOR checksum byte over the data bytes.
//   Each completed word is written to IMEM one cycle after its 4th byte.
//   The core is held in reset until a load finishes with a good checksum.
//   Ports:
//     CLK  - clock, rising edge
//     RST  - synchronous active-high reset
//     bus  - imem_loader_if.slave (handshake, IMEM write bus, status)
module imem_loader #(
    parameter int AWIDTH    = 10,
    parameter int BASE_ADDR = 0
) (
    input  logic          CLK,
    input  logic          RST,
    imem_loader_if.slave  bus
);
    // Largest word count that still fits between BASE_ADDR and the top of IMEM.
    localparam int unsigned LIMIT = (1 << AWIDTH) - BASE_ADDR;

    typedef enum logic [2:0] {
        S_IDLE, S_LEN0, S_LEN1, S_DATA, S_CHK, S_DONE, S_ERR
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_ready;
    logic [15:0]       r_count;
    logic [15:0]       r_wcnt;
    logic [7:0]        r_csum;
    logic [1:0]        r_bidx;
    logic [23:0]       r_word_p0;
    logic              r_vld_p1;
    logic [AWIDTH-1:0] r_addr_p1;
    logic [31:0]       r_wdata_p1;

    logic              w_xfer;
    logic              w_clear;
    logic              w_data_byte;
    logic              w_byte3;
    logic              w_tail;
    logic [15:0]       w_len;

    assign w_xfer  = bus.in_valid & r_ready;
    assign w_len   = {bus.in_data, r_count[7:0]};
    assign w_byte3 = w_data_byte && (r_bidx == 2'd3);
    // Write cycle of the final word: the count already includes it, so a byte
    // accepted now is the checksum.
    assign w_tail  = r_vld_p1 && (r_wcnt == r_count);

    always_comb begin
        w_state_nxt = r_state;
        w_clear     = 1'b0;
        w_data_byte = 1'b0;
        case (r_state)
            S_IDLE, S_DONE, S_ERR: begin
                if (bus.start) begin
                    w_state_nxt = S_LEN0;
                    w_clear     = 1'b1;
                end
            end
            S_LEN0: if (w_xfer) w_state_nxt = S_LEN1;
            S_LEN1: begin
                if (w_xfer) begin
                    if (32'(w_len) > LIMIT) w_state_nxt = S_ERR;
                    else if (w_len == 16'd0) w_state_nxt = S_CHK;
                    else                     w_state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                if (w_tail) begin
                    if (w_xfer) w_state_nxt = (bus.in_data == r_csum) ? S_DONE : S_ERR;
                    else        w_state_nxt = S_CHK;
                end else if (w_xfer) begin
                    w_data_byte = 1'b1;
                end
            end
            S_CHK: begin
                if (w_xfer) w_state_nxt = (bus.in_data == r_csum) ? S_DONE : S_ERR;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state    <= S_IDLE;
            r_ready    <= 1'b0;
            r_count    <= '0;
            r_wcnt     <= '0;
            r_csum     <= '0;
            r_bidx     <= '0;
            r_vld_p1   <= 1'b0;
            r_addr_p1  <= AWIDTH'(BASE_ADDR);
            r_wdata_p1 <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_ready  <= (w_state_nxt inside {S_LEN0, S_LEN1, S_DATA, S_CHK});
            r_vld_p1 <= w_byte3;
            if (w_clear) begin
                r_count <= '0;
                r_wcnt  <= '0;
                r_csum  <= '0;
                r_bidx  <= '0;
            end
            if (r_state == S_LEN0 && w_xfer) r_count[7:0]  <= bus.in_data;
            if (r_state == S_LEN1 && w_xfer) r_count[15:8] <= bus.in_data;
            // Stage p0: byte assembly and running checksum
            if (w_data_byte) begin
                r_csum <= r_csum ^ bus.in_data;
                r_bidx <= r_bidx + 2'd1;
            end
            // Stage p1: registered IMEM write, address taken before the count bumps
            if (w_byte3) begin
                r_wdata_p1 <= {bus.in_data, r_word_p0};
                r_addr_p1  <= AWIDTH'(BASE_ADDR) + r_wcnt[AWIDTH-1:0];
                r_wcnt     <= r_wcnt + 16'd1;
            end
        end
    end

    // Partial word holds bytes 0..2; byte 3 goes straight into the write register.
    always_ff @(posedge CLK) begin
        if (w_data_byte) begin
            case (r_bidx)
                2'd0:    r_word_p0[7:0]   <= bus.in_data;
                2'd1:    r_word_p0[15:8]  <= bus.in_data;
                2'd2:    r_word_p0[23:16] <= bus.in_data;
                default: r_word_p0        <= r_word_p0;
            endcase
        end
    end

    assign bus.in_ready   = r_ready;
    assign bus.imem_we    = r_vld_p1;
    assign bus.imem_addr  = r_addr_p1;
    assign bus.imem_wdata = r_wdata_p1;
    assign bus.word_cnt   = r_wcnt;
    assign bus.done       = (r_state == S_DONE);
    assign bus.error      = (r_state == S_ERR);
    assign bus.cpu_hold   = (r_state != S_DONE);
endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Byte-stream program loader; the write side of instruction memory, which the fetch path and control decode later read.
- Accepts a framed byte stream (length header, little-endian instruction words, XOR checksum) over a valid/ready handshake.
- Assembles the bytes into 32-bit words and writes them to sequential IMEM word addresses.
- Holds the core in reset until a clean load completes.

Parameters:
- AWIDTH, 10, IMEM word-address width; depth = 2^AWIDTH words.
- BASE_ADDR, 0, first IMEM word address written (AWIDTH bits).

Ports:
- CLK  in  1  clock; all logic on rising edge.
- RST  in  1  synchronous, active-high reset.
- start  in  1  begin a new load (honoured only in IDLE, DONE, ERR).
- in_valid  in  1  in_data holds a byte.
- in_data  in  8  stream byte.
- in_ready  out  1  loader accepts a byte this cycle.
- imem_we  out  1  IMEM write strobe, one cycle per word.
- imem_addr  out  AWIDTH  IMEM word address.
- imem_wdata  out  32  instruction word.
- cpu_hold  out  1  core held in reset while 1.
- done  out  1  load completed with good checksum.
- error  out  1  load aborted (length overflow or checksum mismatch).
- word_cnt  out  16  words written in the current or last load.

Behaviour:
- Reset values: in_ready=0, imem_we=0, imem_addr=BASE_ADDR, imem_wdata=0, cpu_hold=1, done=0, error=0, word_cnt=0. State=IDLE.
- Byte transfer: occurs only on a cycle with in_valid & in_ready. in_ready is registered. It is 1 in LEN0, LEN1, DATA and CHK, and 0 elsewhere. in_data is ignored when no transfer occurs.
- Frame format:
  - LEN0 = count[7:0], then LEN1 = count[15:8].
  - count*4 data bytes; within each word, the first byte is bits [7:0] (little-endian).
  - One checksum byte = XOR of all data bytes; header bytes are excluded.
- States:
  - IDLE: wait for start. On start: go to LEN0, clear word_cnt, checksum, byte index and flags; cpu_hold stays 1.
  - LEN0: on transfer, latch the low count byte -> LEN1.
  - LEN1: on transfer, latch the high count byte. If count > 2^AWIDTH - BASE_ADDR -> ERR. If count = 0 -> CHK. Otherwise -> DATA.
  - DATA: each transfer XORs the byte into the checksum and places it at the byte index (0..3). After byte 3:
    - next cycle: imem_we=1, imem_addr=BASE_ADDR+word_cnt, imem_wdata=assembled word;
    - in that same cycle word_cnt increments;
    - after the last word -> CHK.
  - CHK: on transfer, compare the byte with the running XOR. Match -> DONE; mismatch -> ERR.
  - DONE: done=1, cpu_hold=0; hold until start (-> LEN0, done=0, cpu_hold=1).
  - ERR: error=1, cpu_hold=1; hold until start (-> LEN0, error=0).
- Write latency: 1 cycle from the 4th byte's transfer to the imem_we pulse. in_ready stays 1 during the write cycle, so back-to-back bytes stream at 1 byte/cycle. The next word's byte 0 may be accepted in the same cycle as the previous word's write.
- imem_we is never asserted outside DATA. The last word's write is issued before the CHK state is entered.
- start is ignored in LEN0, LEN1, DATA and CHK.
- RST mid-load: return to IDLE with the reset values above. The partial word is discarded. Words already written remain in IMEM.
- Arithmetic: word_cnt and count are 16-bit unsigned. imem_addr = BASE_ADDR + word_cnt[AWIDTH-1:0]; it never wraps, because overflow is rejected in LEN1.

Test Plan:
- Nominal load, BASE_ADDR=0, 1 byte/cycle stream:
  - stimulus: start, bytes 02 00 | 13 05 A0 00 | 93 05 10 00 | checksum.
  - required: imem_we pulses at addr 0 with 0x00A00513 and at addr 1 with 0x00100593; word_cnt=2; done=1, cpu_hold=0.
- Checksum mismatch, same frame with a wrong checksum byte -> error=1, cpu_hold=1, done=0; both words already written.
- Throttled source: in_valid toggled every other cycle on the nominal frame -> identical writes and result; no extra imem_we pulses.
- Length overflow, AWIDTH=4, header 11 00 (17 words) -> ERR right after LEN1; no imem_we; in_ready=0.
- Zero length: header 00 00, checksum 00 -> done=1, word_cnt=0, no writes. Checksum 01 -> error=1.
- RST asserted after the 6th byte of the nominal frame:
  - required: outputs return to reset values; one word remains written at addr 0.
  - a fresh start plus the full frame then completes with done=1.
